// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: decoder states,
// prefix byte constants and the frame check used by the receiver.
package ps2_kbd_rx_pkg;

    typedef enum logic [1:0] {
        KBD_IDLE,
        KBD_EXT,
        KBD_BRK,
        KBD_EXT_BRK
    } kbd_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int FRAME_BITS = 11;

    // Frame layout, bit 0 first on the wire: start, D0..D7, parity, stop.
    // Good frame: start low, stop high, odd parity over data plus parity bit.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, shifts in 11-bit frames on
// falling ps2_clk edges, checks framing/parity and aborts stalled frames.
module ps2_frame_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       byte_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]            clk_sync_q;
    logic [1:0]            data_sync_q;
    logic                  clk_prev_q;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [TW-1:0]         to_q, to_d;
    logic [7:0]            byte_q, byte_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  fall;

    assign fall = clk_prev_q & ~clk_sync_q[1];

    // Two-flop synchronizers plus a history flop for falling-edge detection;
    // lines idle high, so everything resets to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    // Shift, bit count and stall timer; a result pulses the cycle after the last edge.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (fall) begin
            shift_d = {data_sync_q[1], shift_q[FRAME_BITS-1:1]};
            to_d    = '0;
            if (cnt_q == 4'd10) begin
                cnt_d = 4'd0;
                if (frame_ok(shift_d)) begin
                    valid_d = 1'b1;
                    byte_d  = shift_d[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (cnt_q != 4'd0) begin
            if (to_q == TO_LAST) begin
                cnt_d = 4'd0;
                to_d  = '0;
                err_d = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= 4'd0;
            to_q    <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign byte_err_o   = err_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: frame receiver plus a scan-code decoder that
// tracks E0/F0 prefixes, the held key, typematic repeats and a press count.
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       pressing,
    output logic       extended,
    output logic [7:0] key_count,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    kbd_state_e state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       pressing_q, pressing_d;
    logic       extended_q, extended_d;
    logic [7:0] count_q, count_d;
    logic       ready_q, ready_d;
    logic       ferr_q, ferr_d;
    logic       is_ext;

    ps2_frame_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .byte_err_o   (rx_err)
    );

    assign is_ext = (state_q == KBD_EXT) || (state_q == KBD_EXT_BRK);

    // Decoder next state: prefixes move between states, make/break bytes update the held key.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        pressing_d = pressing_q;
        extended_d = extended_q;
        count_d    = count_q;
        ready_d    = 1'b0;
        ferr_d     = 1'b0;
        if (rx_err) begin
            ferr_d  = 1'b1;
            state_d = KBD_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                KBD_IDLE, KBD_EXT: begin
                    if (rx_byte == PS2_EXT) begin
                        state_d = KBD_EXT;
                    end else if (rx_byte == PS2_BRK) begin
                        state_d = (state_q == KBD_EXT) ? KBD_EXT_BRK : KBD_BRK;
                    end else begin
                        state_d = KBD_IDLE;
                        if (!pressing_q || (rx_byte != data_q) || (is_ext != extended_q)) begin
                            data_d     = rx_byte;
                            extended_d = is_ext;
                            pressing_d = 1'b1;
                            ready_d    = 1'b1;
                            count_d    = count_q + 8'd1;
                        end
                    end
                end
                KBD_BRK, KBD_EXT_BRK: begin
                    if ((rx_byte != PS2_EXT) && (rx_byte != PS2_BRK)) begin
                        state_d = KBD_IDLE;
                        if ((rx_byte == data_q) && (is_ext == extended_q)) begin
                            pressing_d = 1'b0;
                        end
                    end
                end
                default: state_d = KBD_IDLE;
            endcase
        end
    end

    // Decoder state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= KBD_IDLE;
            data_q     <= 8'h00;
            pressing_q <= 1'b0;
            extended_q <= 1'b0;
            count_q    <= 8'h00;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            pressing_q <= pressing_d;
            extended_q <= extended_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data       = data_q;
    assign data_ready = ready_q;
    assign pressing   = pressing_q;
    assign extended   = extended_q;
    assign key_count  = count_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: a driver sends PS/2 frames and updates a
// key-level model; a monitor checks every data_ready and every state snapshot.
module tb_ps2_kbd_rx;

    localparam int TIMEOUT = 60;
    localparam int H       = 4;
    localparam int GAP     = 10;

    typedef struct {
        logic [7:0] data;
        logic       ext;
        logic [7:0] cnt;
        int         expCyc;
    } press_t;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       press;
        logic       ext;
        logic [7:0] cnt;
        int         errs;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] data;
    logic       dataReady;
    logic       pressing;
    logic       extended;
    logic [7:0] keyCount;
    logic       frameErr;

    press_t pressQ[$];
    snap_t  snapQ[$];
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     errSeen = 0;
    bit     prevReady = 1'b0;

    // key-level reference model
    logic [7:0] mHeld;
    logic       mExt;
    logic       mPress;
    int         mCount;
    bit         extSeen;
    bit         brkSeen;
    int         errExp = 0;
    int         snapId = 0;

    ps2_kbd_rx #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2Clk),
        .ps2_data   (ps2Data),
        .data       (data),
        .data_ready (dataReady),
        .pressing   (pressing),
        .extended   (extended),
        .key_count  (keyCount),
        .frame_err  (frameErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on data_ready, snapshots compared when requested.
    always @(negedge clk) begin
        press_t e;
        snap_t  s;
        if (snapQ.size() > 0) begin
            s = snapQ.pop_front();
            checkOutput($sformatf("snap%0d.data", s.id), {24'h0, data}, {24'h0, s.data});
            checkOutput($sformatf("snap%0d.pressing", s.id), {31'h0, pressing}, {31'h0, s.press});
            checkOutput($sformatf("snap%0d.extended", s.id), {31'h0, extended}, {31'h0, s.ext});
            checkOutput($sformatf("snap%0d.key_count", s.id), {24'h0, keyCount}, {24'h0, s.cnt});
            checkOutput($sformatf("snap%0d.frame_errs", s.id), errSeen, s.errs);
            checkOutput($sformatf("snap%0d.ready_idle", s.id), {31'h0, dataReady}, 32'h0);
            checkOutput($sformatf("snap%0d.pending", s.id), pressQ.size(), 32'h0);
        end
        if (dataReady) begin
            if (prevReady) begin
                total++;
                bad++;
                $display("[TB] FAIL data_ready pulse: high for 2 cycles, required 1");
            end else if (pressQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL data_ready unexpected: got pulse data=%0h, required none", data);
            end else begin
                e = pressQ.pop_front();
                checkOutput("press.data", {24'h0, data}, {24'h0, e.data});
                checkOutput("press.extended", {31'h0, extended}, {31'h0, e.ext});
                checkOutput("press.key_count", {24'h0, keyCount}, {24'h0, e.cnt});
                checkOutput("press.pressing", {31'h0, pressing}, 32'h1);
                checkOutput("press.latency_cycle", cyc, e.expCyc);
            end
        end else if (pressQ.size() > 0 && cyc > pressQ[0].expCyc) begin
            total++;
            bad++;
            $display("[TB] FAIL data_ready missing: got none by cycle %0d, required at %0d", cyc, pressQ[0].expCyc);
            void'(pressQ.pop_front());
        end
        if (frameErr) errSeen++;
        prevReady = dataReady;
    end

    task automatic modelReset();
        mHeld = 8'h00; mExt = 1'b0; mPress = 1'b0; mCount = 0;
        extSeen = 1'b0; brkSeen = 1'b0;
    endtask

    task automatic modelError();
        errExp++;
        extSeen = 1'b0;
        brkSeen = 1'b0;
    endtask

    task automatic modelByte(input logic [7:0] b, input int readyCyc);
        press_t e;
        if (b == 8'hE0) begin
            if (!brkSeen) extSeen = 1'b1;
        end else if (b == 8'hF0) begin
            brkSeen = 1'b1;
        end else begin
            if (brkSeen) begin
                if (b == mHeld && extSeen == mExt) mPress = 1'b0;
            end else if (!mPress || b != mHeld || extSeen != mExt) begin
                mHeld  = b;
                mExt   = extSeen;
                mPress = 1'b1;
                mCount = (mCount + 1) % 256;
                e.data = b; e.ext = extSeen; e.cnt = 8'(mCount); e.expCyc = readyCyc;
                pressQ.push_back(e);
            end
            extSeen = 1'b0;
            brkSeen = 1'b0;
        end
    endtask

    // Drive nBits of a frame; the model learns the outcome at the 11th falling edge.
    task automatic applyStimulus(input logic [7:0] b, input bit badPar, input int nBits);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ badPar, b, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            @(negedge clk);
            ps2Data = f[i];
            repeat (H) @(negedge clk);
            ps2Clk = 1'b0;
            if (i == 10) begin
                if (badPar) modelError();
                else modelByte(b, cyc + 4);
            end
            repeat (H) @(negedge clk);
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic sendKey(input logic [7:0] b);
        applyStimulus(b, 1'b0, 11);
    endtask

    task automatic requestSnap(input logic [7:0] d, input logic p, input logic x, input logic [7:0] c);
        snap_t s;
        s.id = snapId; s.data = d; s.press = p; s.ext = x; s.cnt = c; s.errs = errExp;
        snapId++;
        snapQ.push_back(s);
        repeat (2) @(negedge clk);
    endtask

    task automatic snapModel();
        repeat (4) @(negedge clk);
        requestSnap(mHeld, mPress, mExt, 8'(mCount));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        ps2Clk = 1'b1;
        ps2Data = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        requestSnap(8'h00, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] pool [7];
        pool[0] = 8'h1C; pool[1] = 8'h1D; pool[2] = 8'h75; pool[3] = 8'hE0;
        pool[4] = 8'hF0; pool[5] = 8'h16; pool[6] = 8'h45;
        modelReset();
        doReset();

        // press and release
        sendKey(8'h1C); snapModel();
        sendKey(8'hF0); sendKey(8'h1C); snapModel();

        // typematic repeat
        sendKey(8'h1C); sendKey(8'h1C); sendKey(8'h1C); snapModel();

        // extended key; plain break of it must not release
        sendKey(8'hE0); sendKey(8'h75); snapModel();
        sendKey(8'hF0); sendKey(8'h75); snapModel();
        sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h75); snapModel();

        // parity error then good frame
        applyStimulus(8'h16, 1'b1, 11); snapModel();
        sendKey(8'h16); snapModel();

        // stalled frame aborted by timeout
        applyStimulus(8'h45, 1'b0, 5);
        repeat (TIMEOUT + 5) @(negedge clk);
        modelError();
        snapModel();
        sendKey(8'h45); snapModel();

        // 256 accepted presses wrap the count back to zero
        doReset();
        for (int i = 0; i < 256; i++) sendKey((i % 2 == 0) ? 8'h1C : 8'h1D);
        snapModel();

        // reset in the middle of a frame
        applyStimulus(8'h33, 1'b0, 5);
        doReset();
        sendKey(8'h45); snapModel();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            applyStimulus(pool[$urandom_range(0, 6)], ($urandom_range(0, 7) == 0), 11);
        end
        snapModel();

        repeat (20) @(negedge clk);
        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
